// File: rtl/wb_mem_stage.sv
// MEM->WB segment register with an embedded 32-bit data memory: sub-word stores, extended loads, misalign detect.
// Define WBMEM_DEBUG_PORT_EN to add the byte-writable debug/loader port B (otherwise rd2 is tied to 0).
module wb_mem_stage #(
    parameter int ADDR_W = 12,
    parameter int RD_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clear,
    input  logic [31:0]     a_m,
    input  logic [31:0]     wd_m,
    input  logic [1:0]      st_size_m,
    input  logic [2:0]      ld_type_m,
    input  logic [31:0]     result_m,
    input  logic [RD_W-1:0] rd_m,
    input  logic            reg_write_m,
    input  logic            mem_to_reg_m,
    output logic [31:0]     result_w,
    output logic [RD_W-1:0] rd_w,
    output logic            reg_write_w,
    output logic            mem_to_reg_w,
    output logic [31:0]     load_data_w,
    output logic            misalign_w,
    input  logic [31:0]     a2,
    input  logic [31:0]     wd2,
    input  logic [3:0]      we2,
    output logic [31:0]     rd2
);
    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_BYTE = 2'b01;
    localparam logic [1:0] ST_HALF = 2'b10;
    localparam logic [1:0] ST_WORD = 2'b11;
    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LBU  = 3'b010;
    localparam logic [2:0] LD_LH   = 3'b011;
    localparam logic [2:0] LD_LHU  = 3'b100;
    localparam logic [2:0] LD_LW   = 3'b101;

    logic [31:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] idx_a;
    logic [1:0]        off;
    logic              is_load, is_half, is_word, misaligned, we_a;
    logic [3:0]        be_a;
    logic [31:0]       wdata_a;

    logic [31:0]     result_d, result_q, rdata_d, rdata_q;
    logic [RD_W-1:0] rd_d, rd_q;
    logic            reg_write_d, reg_write_q, mem_to_reg_d, mem_to_reg_q;
    logic            misalign_d, misalign_q;
    logic [2:0]      ld_type_d, ld_type_q;
    logic [1:0]      off_d, off_q;

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] lt,
                                                input logic [1:0] sel_off);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = word >> {sel_off, 3'b000};
        b  = sh[7:0];
        h  = sel_off[1] ? word[31:16] : word[15:0];
        case (lt)
            LD_LB:   extend_load = 32'(b);
            LD_LBU:  extend_load = {24'b0, b};
            LD_LH:   extend_load = 32'(h);
            LD_LHU:  extend_load = {16'b0, h};
            LD_LW:   extend_load = word;
            default: extend_load = 32'b0;
        endcase
    endfunction

    always_comb begin
        idx_a      = a_m[ADDR_W+1:2];
        off        = a_m[1:0];
        is_load    = (ld_type_m >= LD_LB) && (ld_type_m <= LD_LW);
        is_half    = (st_size_m == ST_HALF) || (ld_type_m == LD_LH) || (ld_type_m == LD_LHU);
        is_word    = (st_size_m == ST_WORD) || (ld_type_m == LD_LW);
        misaligned = (is_half && off[0]) || (is_word && (off != 2'b00));
        case (st_size_m)
            ST_BYTE: be_a = 4'b0001 << off;
            ST_HALF: be_a = 4'b0011 << off;
            ST_WORD: be_a = 4'b1111;
            default: be_a = 4'b0000;
        endcase
        wdata_a = wd_m << {off, 3'b000};
        we_a    = en && !clear && (st_size_m != ST_NONE) && !misaligned;
    end

    // Port B lanes are written first so port A wins any overlapping byte on a same-word collision.
    always_ff @(posedge clk) begin
`ifdef WBMEM_DEBUG_PORT_EN
        for (int i = 0; i < 4; i++)
            if (we2[i]) mem[a2[ADDR_W+1:2]][8*i +: 8] <= wd2[8*i +: 8];
`endif
        if (we_a)
            for (int i = 0; i < 4; i++)
                if (be_a[i]) mem[idx_a][8*i +: 8] <= wdata_a[8*i +: 8];
    end

    always_comb begin
        result_d     = result_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        misalign_d   = misalign_q;
        ld_type_d    = ld_type_q;
        off_d        = off_q;
        rdata_d      = rdata_q;
        if (en) begin
            rdata_d = mem[idx_a];
            if (clear) begin
                result_d     = '0;
                rd_d         = '0;
                reg_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                misalign_d   = 1'b0;
                ld_type_d    = LD_NONE;
                off_d        = 2'b00;
            end else begin
                result_d     = result_m;
                rd_d         = rd_m;
                reg_write_d  = reg_write_m && !(misaligned && is_load);
                mem_to_reg_d = mem_to_reg_m;
                misalign_d   = misaligned && (is_load || (st_size_m != ST_NONE));
                ld_type_d    = is_load ? ld_type_m : LD_NONE;
                off_d        = off;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q     <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            misalign_q   <= 1'b0;
            ld_type_q    <= LD_NONE;
            off_q        <= 2'b00;
            rdata_q      <= '0;
        end else begin
            result_q     <= result_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            misalign_q   <= misalign_d;
            ld_type_q    <= ld_type_d;
            off_q        <= off_d;
            rdata_q      <= rdata_d;
        end
    end

    assign result_w     = result_q;
    assign rd_w         = rd_q;
    assign reg_write_w  = reg_write_q;
    assign mem_to_reg_w = mem_to_reg_q;
    assign misalign_w   = misalign_q;
    assign load_data_w  = misalign_q ? 32'b0 : extend_load(rdata_q, ld_type_q, off_q);

`ifdef WBMEM_DEBUG_PORT_EN
    logic [31:0] rd2_d, rd2_q;
    logic        unused_addr_bits;

    always_comb rd2_d = mem[a2[ADDR_W+1:2]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd2_q <= '0;
        else        rd2_q <= rd2_d;
    end

    assign rd2 = rd2_q;
    assign unused_addr_bits = ^{a_m[31:ADDR_W+2], a2[31:ADDR_W+2], a2[1:0]};
`else
    logic unused_debug_port;

    assign rd2 = '0;
    assign unused_debug_port = ^{a_m[31:ADDR_W+2], a2, wd2, we2};
`endif
endmodule

// File: doc/wb_mem_stage.md
# wb_mem_stage

Parametrised write-back segment register with an embedded synchronous data memory, used between the MEM and WB stages of the RISC-V pipeline. It performs aligned sub-word stores, with byte-enable and lane generation done internally, and sub-word loads with sign/zero extension. It detects misaligned accesses and carries the MEM→WB control fields. Stall and flush are honoured across the memory's one-cycle read latency. A second memory port for debug/loader access is optional.

## Interface
Parameters:
- ADDR_W, 12, word-address width; memory depth is 2**ADDR_W words of 32 bits
- RD_W, 5, destination-register index width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  stage enable; 0 = stall (hold all WB outputs)
- clear  in  1  flush; when en=1, the MEM instruction is squashed
- a_m  in  32  byte address from MEM
- wd_m  in  32  store data, value in bits [7:0]/[15:0]/[31:0]
- st_size_m  in  2  00 none, 01 byte, 10 half, 11 word
- ld_type_m  in  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; others = none
- result_m  in  32  ALU result
- rd_m  in  RD_W  destination register
- reg_write_m  in  1  register-write enable
- mem_to_reg_m  in  1  select load data in WB
- result_w  out  32  registered result_m
- rd_w  out  RD_W  registered rd_m
- reg_write_w  out  1  registered reg_write_m, forced 0 on misaligned load
- mem_to_reg_w  out  1  registered mem_to_reg_m
- load_data_w  out  32  extended load data
- misalign_w  out  1  misaligned access flag for the WB instruction
- a2  in  32  debug byte address (word = a2[ADDR_W+1:2])
- wd2  in  32  debug write data
- we2  in  4  debug byte-write enables
- rd2  out  32  debug read data, one-cycle latency

## Operation
- Word index is a_m[ADDR_W+1:2]. Upper address bits are ignored.
- Offset off = a_m[1:0].
- Misaligned: half with off[0]=1, word with off≠0. This applies to both loads and stores.
- Store byte enables:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
- Store data is wd_m shifted left by 8·off.
- Port A write commits iff en=1, clear=0, st_size_m≠00, and the access is not misaligned.
- Port A read register updates only when en=1 (read-first: a same-edge write is not visible).
- MEM→WB register, on an edge with en=1:
  - clear=1 loads result_w, rd_w, reg_write_w, mem_to_reg_w, misalign_w, the latched ld_type, and the latched off with 0.
  - Otherwise these fields load the MEM values.
  - misalign_w = misaligned & (ld_type_m≠none | st_size_m≠00).
  - reg_write_w = reg_write_m & ~(misaligned & load).
- With en=0, every register holds. load_data_w is formed from held state only, so it is stable across stalls of any length.
- load_data_w, computed combinationally in WB from the RAM word, latched ld_type and latched off:
  - LB/LBU: byte at off, sign- or zero-extended.
  - LH/LHU: halfword at off[1], sign- or zero-extended.
  - LW: full word.
  - none, cleared, or misaligned: 0.
- Port B: write word bytes where we2[i]=1, read-first, independent of en/clear.
- Port A/B same-word same-edge writes: port A bytes win on overlapping lanes, port B writes the remaining lanes.

## Timing
- Store: memory updated at the edge ending the MEM cycle. A load in the next instruction returns the new data.
- Load: address sampled at the edge entering WB. load_data_w is valid in that same WB cycle (latency 1 edge).
- Reset (rst_n=0, asynchronous): all *_w outputs, misalign_w, load_data_w, rd2 and the read registers go to 0. Memory contents are not reset.
- Reset released mid-stall: registers stay 0 until the first edge with en=1.
- Clear takes effect only when en=1. Clear with en=0 is ignored.

## Configuration
- WBMEM_DEBUG_PORT_EN defined: port B is present as described.
- Not defined: port B logic is removed, a2/wd2/we2 are ignored, and rd2 is tied to 0. The memory becomes single-port.

## Test plan
- SB then LB/LBU/LH:
  - SW 0x00000000 @0x10, SB wd_m=0x000000F0 @0x13, LW @0x10 → load_data_w=0xF0000000.
  - LB @0x13 → 0xFFFFFFF0.
  - LBU @0x13 → 0x000000F0.
- SH @0x22 with wd_m=0x12348001, then LH @0x22 → 0xFFFF8001, LHU → 0x00008001. The word @0x20 lower half is unchanged.
- Misaligned:
  - LW @0x21 → misalign_w=1, reg_write_w=0, load_data_w=0.
  - SH @0x23 → memory unchanged, misalign_w=1.
- Stall/flush:
  - LW @0x10 enters WB, then en=0 for 3 cycles while port B writes 0xDEADBEEF @0x10 → load_data_w holds the old value throughout.
  - clear=1 with a SW in MEM → memory unchanged, all *_w outputs=0 next cycle.
- Asynchronous reset mid-load: assert rst_n=0 between edges → all outputs 0 immediately. Memory data written before reset is still readable afterwards.
- Collision: same edge, port A SB 0xAA @0x40 and port B we2=1111 wd2=0x11223344 @0x40 → word reads 0x112233AA.
